// File: rtl/bsg_downstream_link_rx.sv
`default_nettype none
// ============================================================================
// Module  : bsg_downstream_link_rx
// Brief   : Reassembles 64-bit words from 16-bit link beats, buffers them for
//           the core and returns one credit token per batch of consumed words.
// Revision: 1.0  initial release
// ============================================================================
module bsg_downstream_link_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TOKEN_BATCH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_valid_in,
    input  logic [7:0]  io_data_in_ch0,
    input  logic [7:0]  io_data_in_ch1,
    output logic        core_valid_out,
    output logic [63:0] core_data_out,
    input  logic        core_yumi_in,
    output logic        io_token,
    output logic        overflow_err
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_TOK_W  = $clog2(TOKEN_BATCH);

    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TOK_W-1:0] c_LAST_POP   = c_TOK_W'(TOKEN_BATCH - 1);

    logic [1:0]          r_beat_cnt;
    logic [47:0]         r_partial;
    logic [63:0]         r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_TOK_W-1:0]  r_consumed_cnt;
    logic                r_token;
    logic                r_overflow;

    logic        w_word_done;
    logic [63:0] w_word;
    logic        w_valid;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_drop;

    // Final beat is joined straight into the word, so only 48 bits need staging.
    assign w_word_done = io_valid_in && (r_beat_cnt == 2'd3);
    assign w_word      = {io_data_in_ch1, io_data_in_ch0, r_partial};

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_pop     = core_yumi_in && w_valid;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign w_push_ok = w_word_done && (!w_full || w_pop);
    assign w_drop    = w_word_done && w_full && !w_pop;

    // Beat assembler
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= 2'd0;
            r_partial  <= '0;
        end else if (io_valid_in) begin
            r_beat_cnt <= r_beat_cnt + 2'd1;
            case (r_beat_cnt)
                2'd0:    r_partial[15:0]  <= {io_data_in_ch1, io_data_in_ch0};
                2'd1:    r_partial[31:16] <= {io_data_in_ch1, io_data_in_ch0};
                2'd2:    r_partial[47:32] <= {io_data_in_ch1, io_data_in_ch0};
                default: r_partial        <= r_partial;
            endcase
        end
    end

    // Storage array carries no reset; reads are masked by the valid flag.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Credit return: one pulse when a pop completes a batch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_consumed_cnt <= '0;
            r_token        <= 1'b0;
        end else begin
            r_token <= w_pop && (r_consumed_cnt == c_LAST_POP);
            if (w_pop) begin
                r_consumed_cnt <= r_consumed_cnt + c_TOK_W'(1);
            end
        end
    end

    assign core_valid_out = w_valid;
    assign core_data_out  = w_valid ? r_mem[r_rd_ptr] : 64'd0;
    assign io_token       = r_token;
    assign overflow_err   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_link_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_bsg_downstream_link_rx
// Brief   : Directed bench with a queue-based reference of the receive link.
// Revision: 1.0  initial release
// ============================================================================
module tb_bsg_downstream_link_rx;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_valid_in = 1'b0;
    logic [7:0]  io_data_in_ch0 = 8'd0;
    logic [7:0]  io_data_in_ch1 = 8'd0;
    logic        core_yumi_in = 1'b0;
    logic        core_valid_out;
    logic [63:0] core_data_out;
    logic        io_token;
    logic        overflow_err;

    int checks   = 0;
    int failures = 0;
    int tok_seen = 0;
    bit chk_en   = 1'b0;

    // Reference state: the buffered words as a plain queue
    logic [63:0] m_q [$];
    logic [63:0] m_acc   = 64'd0;
    int          m_beat  = 0;
    int          m_pops  = 0;
    bit          m_token = 1'b0;
    bit          m_ovf   = 1'b0;

    bsg_downstream_link_rx #(
        .FIFO_DEPTH (DEPTH),
        .TOKEN_BATCH(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .io_valid_in   (io_valid_in),
        .io_data_in_ch0(io_data_in_ch0),
        .io_data_in_ch1(io_data_in_ch1),
        .core_valid_out(core_valid_out),
        .core_data_out (core_data_out),
        .core_yumi_in  (core_yumi_in),
        .io_token      (io_token),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mkword(input int i);
        logic [15:0] x;
        x = i[15:0];
        return {16'hC0DE, x, 16'hBEEF ^ x, 16'h1234 + x};
    endfunction

    initial begin : model
        bit          pop;
        bit          full;
        logic [63:0] w;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_acc   = 64'd0;
                m_beat  = 0;
                m_pops  = 0;
                m_token = 1'b0;
                m_ovf   = 1'b0;
            end else begin
                full    = (m_q.size() == DEPTH);
                pop     = core_yumi_in && (m_q.size() > 0);
                m_token = 1'b0;
                if (pop) begin
                    void'(m_q.pop_front());
                    m_pops++;
                    if (m_pops % 8 == 0) m_token = 1'b1;
                end
                if (io_valid_in) begin
                    m_acc[16*m_beat +: 16] = {io_data_in_ch1, io_data_in_ch0};
                    if (m_beat == 3) begin
                        w = m_acc;
                        if (full && !pop) m_ovf = 1'b1;
                        else m_q.push_back(w);
                    end
                    m_beat = (m_beat + 1) % 4;
                end
            end
        end
    end

    initial begin : compare
        logic        ev;
        logic [63:0] ed;
        forever begin
            @(negedge clk);
            if (io_token === 1'b1) tok_seen++;
            if (chk_en) begin
                ev = (m_q.size() > 0);
                ed = ev ? m_q[0] : 64'd0;
                chk("cyc_valid", {63'd0, core_valid_out}, {63'd0, ev});
                chk("cyc_data", core_data_out, ed);
                chk("cyc_token", {63'd0, io_token}, {63'd0, m_token});
                chk("cyc_ovf", {63'd0, overflow_err}, {63'd0, m_ovf});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] lo, input logic [7:0] hi);
        io_valid_in    = 1'b1;
        io_data_in_ch0 = lo;
        io_data_in_ch1 = hi;
        tick();
        io_valid_in    = 1'b0;
        io_data_in_ch0 = 8'd0;
        io_data_in_ch1 = 8'd0;
    endtask

    task automatic send_beats(input logic [63:0] w, input int first, input int last, input int gap);
        for (int k = first; k <= last; k++) begin
            beat(w[16*k +: 8], w[16*k+8 +: 8]);
            if (k < 3) repeat (gap) tick();
        end
    endtask

    task automatic send_word(input logic [63:0] w, input int gap);
        send_beats(w, 0, 3, gap);
    endtask

    task automatic pops(input int n);
        core_yumi_in = 1'b1;
        repeat (n) tick();
        core_yumi_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin : stim
        int t0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_valid", {63'd0, core_valid_out}, 64'd0);
        chk("rst_data", core_data_out, 64'd0);
        chk("rst_token", {63'd0, io_token}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_err}, 64'd0);
        rst = 1'b1;
        tick();

        // Single contiguous word, then hold without yumi
        send_beats(64'h8877665544332211, 0, 2, 0);
        chk("single_pre_valid", {63'd0, core_valid_out}, 64'd0);
        send_beats(64'h8877665544332211, 3, 3, 0);
        chk("single_valid", {63'd0, core_valid_out}, 64'd1);
        chk("single_data", core_data_out, 64'h8877665544332211);
        repeat (3) tick();
        chk("single_hold", core_data_out, 64'h8877665544332211);
        pops(1);
        chk("single_drained", {63'd0, core_valid_out}, 64'd0);

        // Gapped beats
        send_word(64'h8877665544332211, 3);
        chk("gap_data", core_data_out, 64'h8877665544332211);
        repeat (2) tick();
        pops(1);
        chk("gap_drained", {63'd0, core_valid_out}, 64'd0);

        // Token after 8 pops, then 7 more silent, 1 more pulses
        do_reset();
        for (int i = 0; i < 8; i++) send_word(mkword(i), 0);
        t0 = tok_seen;
        pops(8);
        tick();
        chk("tok_first", 64'(tok_seen - t0), 64'd1);
        for (int i = 8; i < 16; i++) send_word(mkword(i), 0);
        pops(7);
        tick();
        chk("tok_seven", 64'(tok_seen - t0), 64'd1);
        pops(1);
        tick();
        chk("tok_second", 64'(tok_seen - t0), 64'd2);

        // Full FIFO, simultaneous push/pop, then overflow
        do_reset();
        for (int i = 0; i < 16; i++) send_word(mkword(i), 0);
        chk("full_model_count", 64'(m_q.size()), 64'd16);
        chk("full_ovf", {63'd0, overflow_err}, 64'd0);
        chk("full_head", core_data_out, mkword(0));
        send_beats(mkword(16), 0, 2, 0);
        core_yumi_in = 1'b1;
        send_beats(mkword(16), 3, 3, 0);
        core_yumi_in = 1'b0;
        chk("full_pushpop_ovf", {63'd0, overflow_err}, 64'd0);
        chk("full_pushpop_head", core_data_out, mkword(1));
        send_word(mkword(17), 0);
        tick();
        chk("ovf_set", {63'd0, overflow_err}, 64'd1);
        chk("ovf_head", core_data_out, mkword(1));
        send_beats(mkword(18), 0, 2, 0);
        core_yumi_in = 1'b1;
        send_beats(mkword(18), 3, 3, 0);
        core_yumi_in = 1'b0;
        chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
        chk("ovf_pushpop_head", core_data_out, mkword(2));
        pops(16);
        chk("ovf_drained", {63'd0, core_valid_out}, 64'd0);

        // Yumi on an empty FIFO must not advance the batch counter
        do_reset();
        t0 = tok_seen;
        pops(10);
        chk("empty_yumi_tok", 64'(tok_seen - t0), 64'd0);
        for (int i = 0; i < 8; i++) send_word(mkword(40 + i), 0);
        pops(7);
        tick();
        chk("empty_yumi_seven", 64'(tok_seen - t0), 64'd0);
        pops(1);
        tick();
        chk("empty_yumi_eighth", 64'(tok_seen - t0), 64'd1);

        // Asynchronous reset mid-word with 5 words buffered, 3 consumed
        do_reset();
        for (int i = 0; i < 8; i++) send_word(mkword(60 + i), 0);
        pops(3);
        send_beats(mkword(99), 0, 2, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {63'd0, core_valid_out}, 64'd0);
        chk("arst_data", core_data_out, 64'd0);
        chk("arst_token", {63'd0, io_token}, 64'd0);
        chk("arst_ovf", {63'd0, overflow_err}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        send_word(64'hFEDCBA9876543210, 0);
        chk("arst_fresh_word", core_data_out, 64'hFEDCBA9876543210);
        for (int i = 0; i < 7; i++) send_word(mkword(80 + i), 0);
        t0 = tok_seen;
        pops(5);
        tick();
        chk("arst_no_tok_5th", 64'(tok_seen - t0), 64'd0);
        pops(3);
        tick();
        chk("arst_tok_8th", 64'(tok_seen - t0), 64'd1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_downstream_link_rx.md
# bsg_downstream_link_rx

Receive half of the BSG source-synchronous link: the block that sits directly downstream of the upstream transmitter and its TOKEN_IN credit logic. It collects 16-bit beats from two 8-bit I/O channels, reassembles 64-bit core words and buffers them in a FIFO for the core. It returns one `io_token` pulse per 8 words the core consumes; each pulse is worth 8 credits (`finish_cnt += 8`) at the upstream side.

## Interface
- `FIFO_DEPTH`, 16: words of receive buffering; power of two, ≥ 8. Must be ≥ the upstream's initial credit count.
- `TOKEN_BATCH`, 8: words consumed per token pulse; fixed at 8 to match the upstream's +8 credit step.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted when 0).
- `io_valid_in`  in  1  beat present on the channels this cycle.
- `io_data_in_ch0`  in  8  beat low byte.
- `io_data_in_ch1`  in  8  beat high byte.
- `core_valid_out`  out  1  FIFO head word valid.
- `core_data_out`  out  64  FIFO head word; forced to 0 when `core_valid_out`=0.
- `core_yumi_in`  in  1  core consumes head this cycle; legal only when `core_valid_out`=1.
- `io_token`  out  1  one-cycle credit-return pulse to the upstream.
- `overflow_err`  out  1  sticky: a word arrived while the FIFO was full.

## Operation
- **Beat mapping:** 4 beats per word, LSB first.
  - Beat k (k=0..3) carries word[16k+7:16k] on ch0 and word[16k+15:16k+8] on ch1.
- **Assembler:** 2-bit `beat_cnt` and 48-bit partial register.
  - Beats 0–2 are stored and `beat_cnt` increments.
  - Beat 3 is concatenated with the partial register, the word is pushed, and `beat_cnt` wraps to 0.
  - Idle cycles (`io_valid_in`=0) between beats are legal; the partial word is held.
- **FIFO:** circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Memory is not reset.
  - Push on assembled word; pop on `core_yumi_in` && `core_valid_out`.
  - `core_yumi_in` while empty is ignored (no pointer or count change).
  - Full with push and no pop: the word is dropped, `overflow_err` sets and holds until reset, and pointers are unchanged.
  - Full with simultaneous push and pop: both are accepted and the count stays at FIFO_DEPTH; no error.
  - Empty with push: no bypass; the word is visible the next cycle.
- **Token generator:** 3-bit `consumed_cnt` increments per accepted pop.
  - On a pop that wraps it 7→0, `io_token` is registered high for exactly the next cycle.
  - Pops are at most one per cycle, so back-to-back tokens are ≥ 8 cycles apart. No pulse merging is needed.
- **Reset (any time, including mid-word or mid-batch):**
  - `beat_cnt`=0 and the partial word is discarded.
  - FIFO is empty and `consumed_cnt`=0.
  - Outputs: `core_valid_out`=0, `core_data_out`=0, `io_token`=0, `overflow_err`=0.

## Timing
- **Word latency:** beat 3 accepted at edge N → `core_valid_out`=1 with the word during cycle N+1.
- **Throughput:** one word per 4 `io_valid_in` cycles in; one pop per cycle out.
- **Pop:** `core_yumi_in` at edge N → the next head (or `core_valid_out`=0) during cycle N+1.
- **Token:** the 8th pop at edge N → `io_token`=1 during cycle N+1 only.
- `overflow_err` rises in the cycle after the dropped push.
- No combinational path from any input to any output except `core_data_out`/`core_valid_out` from FIFO state (registered).

## Test plan
- **Single word:** beats {ch1,ch0} = {0x22,0x11},{0x44,0x33},{0x66,0x55},{0x88,0x77} contiguous.
  - `core_data_out`=0x8877665544332211 and `core_valid_out`=1 one cycle after beat 3.
  - Hold `core_yumi_in`=0; the data stays stable.
- **Gapped beats:** same beats with 3 idle cycles between each → identical word, no spurious push.
- **Token:**
  - Stream 8 words, then assert yumi on 8 consecutive cycles → exactly one `io_token` pulse, the cycle after the 8th pop.
  - 7 more pops → no pulse; 1 more → pulse.
- **Full/overflow (FIFO_DEPTH=16):**
  - 16 words with no pops → count 16, `overflow_err`=0.
  - A 17th word → dropped, `overflow_err`=1, and head is still word 1.
  - Then push and pop in the same cycle on a full FIFO → accepted, no change to error.
- **Empty yumi:** `core_yumi_in`=1 with an empty FIFO for 10 cycles → no token, and `consumed_cnt` is unchanged (verify by a later 8-pop batch giving one pulse).
- **Reset mid-operation:** assert `rst`=0 after beat 2 of a word with 5 words buffered and `consumed_cnt`=3.
  - All outputs 0 immediately.
  - After release, 4 fresh beats produce one correct word, and 8 pops give a token on the 8th, not the 5th.
